// File: rtl/imem_program_loader.sv
// imem_program_loader
// Parses a framed program image from the UART byte stream and writes it into
// instruction memory one little-endian word at a time. Releases the core via
// `start` once the image has been written and its XOR checksum matches.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | hunting for the MAGIC byte; other bytes are dropped silently
// LEN   | collecting the 32-bit word count, LSB first
// DATA  | assembling payload words and issuing one imem write per word
// CHK   | waiting for the checksum byte
// DONE  | image accepted, start held high until reset
// ERR   | image rejected, error held high until reset

module imem_program_loader #(
    parameter int unsigned IMEM_WORD      = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter logic [7:0]  MAGIC          = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        prog_en,
    output logic [31:0] prog_addr,
    output logic [31:0] prog_data,
    output logic        start,
    output logic        busy,
    output logic        error
);

    // Index must reach IMEM_WORD itself without wrapping.
    localparam int IDX_W = $clog2(IMEM_WORD + 1);
    // Idle timer is a down-counter loaded with TIMEOUT_CYCLES-1 on every byte.
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TMR_W-1:0] TMR_LOAD =
        (TIMEOUT_CYCLES == 0) ? '0 : TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CHK  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t           state;
    logic [31:0]      len_reg;
    logic [31:0]      word_reg;
    logic [1:0]       byte_cnt;
    logic [IDX_W-1:0] index;
    logic [7:0]       xor_acc;
    logic [TMR_W-1:0] timer;

    logic [31:0] len_next;
    logic [31:0] word_next;
    logic        tmo_hit;

    // Bytes arrive LSB first, so both the length and each word shift in from the top.
    assign len_next  = {rx_data, len_reg[31:8]};
    assign word_next = {rx_data, word_reg[31:8]};
    assign tmo_hit   = TMO_EN && (timer == '0);

    // Frame parser, imem write port and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            len_reg   <= '0;
            word_reg  <= '0;
            byte_cnt  <= '0;
            index     <= '0;
            xor_acc   <= '0;
            timer     <= '0;
            prog_en   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
            start     <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b0;
        end else begin
            prog_en <= 1'b0;

            // Inter-byte timer only runs while a frame is open.
            if (busy) begin
                if (rx_valid) begin
                    timer <= TMR_LOAD;
                end else if (timer != '0) begin
                    timer <= timer - TMR_W'(1);
                end
            end

            case (state)
                S_IDLE: begin
                    if (rx_valid && rx_data == MAGIC) begin
                        state    <= S_LEN;
                        busy     <= 1'b1;
                        byte_cnt <= '0;
                        timer    <= TMR_LOAD;
                    end
                end

                S_LEN: begin
                    if (rx_valid) begin
                        len_reg  <= len_next;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            xor_acc <= '0;
                            index   <= '0;
                            if (len_next > 32'(IMEM_WORD)) begin
                                state <= S_ERR;
                                error <= 1'b1;
                                busy  <= 1'b0;
                            end else if (len_next == 32'd0) begin
                                state <= S_CHK;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end else if (tmo_hit) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        byte_cnt <= '0;
                    end
                end

                S_DATA: begin
                    if (rx_valid) begin
                        word_reg <= word_next;
                        xor_acc  <= xor_acc ^ rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            prog_en   <= 1'b1;
                            prog_addr <= BASE_ADDR + (32'(index) << 2);
                            prog_data <= word_next;
                            index     <= index + IDX_W'(1);
                            if (32'(index) + 32'd1 == len_reg) begin
                                state <= S_CHK;
                            end
                        end
                    end else if (tmo_hit) begin
                        // Partial word is dropped; completed writes stay in imem.
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        byte_cnt <= '0;
                    end
                end

                S_CHK: begin
                    if (rx_valid) begin
                        busy <= 1'b0;
                        if (rx_data == xor_acc) begin
                            state <= S_DONE;
                            start <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        byte_cnt <= '0;
                    end
                end

                S_DONE: begin
                    start <= 1'b1;
                end

                S_ERR: begin
                    error <= 1'b1;
                    start <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// Testbench for imem_program_loader: fixed frame table, cycle-exact corner
// sequences, and random frames compared against a frame-level parser model.

module tb_imem_program_loader;

    localparam int          IW    = 16;
    localparam int          TO    = 16;
    localparam logic [31:0] BASE  = 32'h0;
    localparam logic [7:0]  MAGIC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        prog_en;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;
    logic        start;
    logic        busy;
    logic        error;

    always #5 clk = ~clk;

    imem_program_loader #(
        .IMEM_WORD      (IW),
        .BASE_ADDR      (BASE),
        .MAGIC          (MAGIC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .prog_en   (prog_en),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .busy      (busy),
        .error     (error)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];
    logic [7:0]  stim_q[$];
    logic        e_st, e_er, e_bz;

    // Record every imem write as {addr, data}.
    always @(negedge clk) begin
        if (rst === 1'b0 && prog_en === 1'b1) got_q.push_back({prog_addr, prog_data});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's input, return at the following negedge.
    task automatic tick(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        got_q.delete();
    endtask

    // Frame-level reference: scan for MAGIC, read length, slice words, compare checksum.
    task automatic model();
        int          i;
        logic [31:0] len;
        logic [7:0]  x;
        exp_q.delete();
        e_st = 1'b0; e_er = 1'b0; e_bz = 1'b0;
        i = 0;
        while (i < stim_q.size() && stim_q[i] != MAGIC) i++;
        if (i >= stim_q.size()) return;
        i++;
        if (stim_q.size() - i < 4) begin e_bz = 1'b1; return; end
        len = {stim_q[i+3], stim_q[i+2], stim_q[i+1], stim_q[i]};
        i += 4;
        if (len > 32'(IW)) begin e_er = 1'b1; return; end
        x = 8'h00;
        for (int w = 0; w < int'(len); w++) begin
            if (i + 4 > stim_q.size()) begin e_bz = 1'b1; return; end
            exp_q.push_back({BASE + 32'(w * 4),
                             stim_q[i+3], stim_q[i+2], stim_q[i+1], stim_q[i]});
            x = x ^ stim_q[i] ^ stim_q[i+1] ^ stim_q[i+2] ^ stim_q[i+3];
            i += 4;
        end
        if (i >= stim_q.size()) begin e_bz = 1'b1; return; end
        if (stim_q[i] == x) e_st = 1'b1;
        else                e_er = 1'b1;
    endtask

    // Build a random frame (len_sel < 0 picks the length at random).
    task automatic gen_frame(input int len_sel);
        int          len;
        int          r;
        logic [7:0]  b;
        logic [7:0]  x;
        stim_q.delete();
        repeat ($urandom_range(0, 3)) begin
            b = 8'($urandom_range(0, 255));
            if (b == MAGIC) b = 8'h00;
            stim_q.push_back(b);
        end
        stim_q.push_back(MAGIC);
        if (len_sel >= 0) len = len_sel;
        else begin
            r = $urandom_range(0, 9);
            if (r == 0)      len = 0;
            else if (r == 1) len = IW;
            else if (r == 2) len = IW + 1 + $urandom_range(0, 4);
            else             len = $urandom_range(1, 6);
        end
        for (int k = 0; k < 4; k++) stim_q.push_back(8'(len >> (8 * k)));
        if (len <= IW) begin
            x = 8'h00;
            for (int k = 0; k < len * 4; k++) begin
                b = 8'($urandom_range(0, 255));
                x = x ^ b;
                stim_q.push_back(b);
            end
            if (len_sel < 0 && $urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
            stim_q.push_back(x);
        end
        if (len_sel < 0 && $urandom_range(0, 7) == 0) begin
            repeat ($urandom_range(1, 3)) if (stim_q.size() > 1) void'(stim_q.pop_back());
        end
        repeat ($urandom_range(0, 2)) stim_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic run_and_compare(input string tag, input int max_gap);
        int n;
        do_reset();
        foreach (stim_q[k]) begin
            tick(1'b1, stim_q[k]);
            idle($urandom_range(0, max_gap));
        end
        idle(3);
        model();
        check({tag, "_nwr"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            check({tag, "_addr"}, got_q[k][63:32], exp_q[k][63:32]);
            check({tag, "_data"}, got_q[k][31:0],  exp_q[k][31:0]);
        end
        check({tag, "_start"}, 32'(start), 32'(e_st));
        check({tag, "_error"}, 32'(error), 32'(e_er));
        check({tag, "_busy"},  32'(busy),  32'(e_bz));
    endtask

    typedef struct {
        logic [127:0] bytes;   // first byte sent is the leftmost of n bytes
        int           n;
        int           nwr;
        logic [31:0]  last_addr;
        logic [31:0]  last_data;
        logic         st;
        logic         er;
        logic         bz;
    } vec_t;

    vec_t vt[10];

    function automatic logic [7:0] vbyte(input vec_t v, input int i);
        return v.bytes[8*(v.n-1-i) +: 8];
    endfunction

    // Two-word image; checksum of 13 00 00 00 93 00 10 00 is 0x90.
    logic [7:0] good2[14] = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00,
                              8'h13, 8'h00, 8'h00, 8'h00,
                              8'h93, 8'h00, 8'h10, 8'h00, 8'h90};

    initial begin
        vt[0] = '{128'hA5_02000000_13000000_93001000_90,    14, 2, 32'h4, 32'h00100093, 1'b1, 1'b0, 1'b0};
        vt[1] = '{128'hA5_02000000_13000000_93001000_81,    14, 2, 32'h4, 32'h00100093, 1'b0, 1'b1, 1'b0};
        vt[2] = '{128'hA5_02000000_13000000_93001000_81_A5, 15, 2, 32'h4, 32'h00100093, 1'b0, 1'b1, 1'b0};
        vt[3] = '{128'hA5_11000000,                          5, 0, 32'h0, 32'h0,        1'b0, 1'b1, 1'b0};
        vt[4] = '{128'h00FF3C_A5_00000000_00,                9, 0, 32'h0, 32'h0,        1'b1, 1'b0, 1'b0};
        vt[5] = '{128'hA5_01000000_A5000000_A5,             10, 1, 32'h0, 32'h000000A5, 1'b1, 1'b0, 1'b0};
        vt[6] = '{128'hA5_00000000_01,                       6, 0, 32'h0, 32'h0,        1'b0, 1'b1, 1'b0};
        vt[7] = '{128'hA5_010000,                            4, 0, 32'h0, 32'h0,        1'b0, 1'b0, 1'b1};
        vt[8] = '{128'hA5_00000080,                          5, 0, 32'h0, 32'h0,        1'b0, 1'b1, 1'b0};
        vt[9] = '{128'hA5_01000000_EFBEADDE_22,             10, 1, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;

        // Quiet after reset.
        do_reset();
        idle(10);
        check("rst_prog_en", 32'(prog_en), 32'h0);
        check("rst_start",   32'(start),   32'h0);
        check("rst_busy",    32'(busy),    32'h0);
        check("rst_error",   32'(error),   32'h0);
        check("rst_addr",    prog_addr,    32'h0);
        check("rst_data",    prog_data,    32'h0);

        // Fixed frames, back-to-back bytes.
        foreach (vt[v]) begin
            do_reset();
            for (int i = 0; i < vt[v].n; i++) tick(1'b1, vbyte(vt[v], i));
            idle(2);
            check($sformatf("vec%0d_nwr", v), got_q.size(), vt[v].nwr);
            if (vt[v].nwr > 0 && got_q.size() > 0) begin
                check($sformatf("vec%0d_addr", v), got_q[got_q.size()-1][63:32], vt[v].last_addr);
                check($sformatf("vec%0d_data", v), got_q[got_q.size()-1][31:0],  vt[v].last_data);
            end
            check($sformatf("vec%0d_start", v), 32'(start), 32'(vt[v].st));
            check($sformatf("vec%0d_error", v), 32'(error), 32'(vt[v].er));
            check($sformatf("vec%0d_busy", v),  32'(busy),  32'(vt[v].bz));
        end

        // Cycle-exact write strobes and start timing; byte 9 lands on the strobe cycle.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            tick(1'b1, good2[i]);
            if (i == 8) begin
                check("seq_wr0_en",   32'(prog_en), 32'h1);
                check("seq_wr0_addr", prog_addr,    32'h0);
                check("seq_wr0_data", prog_data,    32'h00000013);
            end
            if (i == 9)  check("seq_wr0_single", 32'(prog_en), 32'h0);
            if (i == 12) begin
                check("seq_wr1_en",   32'(prog_en), 32'h1);
                check("seq_wr1_addr", prog_addr,    32'h4);
                check("seq_wr1_data", prog_data,    32'h00100093);
            end
            if (i == 12) check("seq_pre_start", 32'(start), 32'h0);
            if (i == 13) begin
                check("seq_start", 32'(start), 32'h1);
                check("seq_busy",  32'(busy),  32'h0);
            end
        end
        idle(5);
        check("seq_start_held", 32'(start), 32'h1);

        // Oversized length: error the cycle after the 4th length byte.
        do_reset();
        tick(1'b1, MAGIC);
        tick(1'b1, 8'h11);
        tick(1'b1, 8'h00);
        tick(1'b1, 8'h00);
        check("ovf_pre_error", 32'(error), 32'h0);
        check("ovf_pre_busy",  32'(busy),  32'h1);
        tick(1'b1, 8'h00);
        check("ovf_error", 32'(error), 32'h1);
        check("ovf_busy",  32'(busy),  32'h0);
        check("ovf_nwr",   got_q.size(), 0);

        // Timeout mid-word, then a clean frame.
        do_reset();
        tick(1'b1, MAGIC);
        tick(1'b1, 8'h01); tick(1'b1, 8'h00); tick(1'b1, 8'h00); tick(1'b1, 8'h00);
        tick(1'b1, 8'h13); tick(1'b1, 8'h00);
        idle(8);
        check("tmo_still_busy", 32'(busy), 32'h1);
        idle(8);
        check("tmo_busy",  32'(busy),  32'h0);
        check("tmo_error", 32'(error), 32'h0);
        check("tmo_start", 32'(start), 32'h0);
        check("tmo_nwr",   got_q.size(), 0);
        for (int i = 0; i < 14; i++) tick(1'b1, good2[i]);
        idle(2);
        check("tmo_reload_start", 32'(start), 32'h1);
        check("tmo_reload_nwr",   got_q.size(), 2);

        // Reset in the middle of DATA after one word was written.
        do_reset();
        for (int i = 0; i < 10; i++) tick(1'b1, good2[i]);
        check("mid_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_prog_en", 32'(prog_en), 32'h0);
        check("mid_rst_addr",    prog_addr,    32'h0);
        check("mid_rst_data",    prog_data,    32'h0);
        check("mid_rst_busy",    32'(busy),    32'h0);
        check("mid_rst_start",   32'(start),   32'h0);
        check("mid_rst_error",   32'(error),   32'h0);
        rst = 1'b0;

        // Full-depth image: LEN == IMEM_WORD.
        gen_frame(IW);
        run_and_compare("full", 2);
        if (got_q.size() == IW) check("full_last_addr", got_q[IW-1][63:32], BASE + 32'(4 * (IW - 1)));
        else                    check("full_count", got_q.size(), IW);

        // Random frames with small inter-byte gaps.
        for (int t = 0; t < 30; t++) begin
            gen_frame(-1);
            run_and_compare($sformatf("rnd%0d", t), 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
